sample_capture: RTL and testbench
=================================

# sample_capture

Synthesizable capture end for the sample datapath: samples a narrow bus every clock, records each value change with a cycle timestamp into a small FIFO, and lets a host drain the events over a valid/ready port. It is the receiving counterpart to the timed stimulus schedules driven into `sample`: in silicon it replaces the simulator's `$monitor` when observing `B` (or `A`). The block sits beside `sample` and is read by a debug/host interface.

## Interface
- `WIDTH`, 4: width of the observed bus.
- `TS_WIDTH`, 16: timestamp width in clock cycles.
- `DEPTH`, 8: FIFO entries; power of two, at least 2.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  WIDTH  observed bus, synchronous to `clk`.
- `arm`  in  1  start capture (single-cycle pulse or level).
- `stop`  in  1  end capture.
- `out_valid`  out  1  FIFO head holds an event.
- `out_ready`  in  1  host accepts the head event.
- `out_data`  out  WIDTH  captured value of the head event.
- `out_ts`  out  TS_WIDTH  timestamp of the head event.
- `armed`  out  1  high in state ARMED.
- `overflow`  out  1  sticky; at least one event was dropped.
- `drop_cnt`  out  8  dropped events, saturating at 255.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- States: IDLE, FIRST, ARMED.
- IDLE: no capture, timestamp held at 0. `arm`=1 moves to FIRST. The FIFO can still be drained.
- FIRST, one cycle: push `{din, ts=0}` unconditionally, matching the monitor's initial print. Load `last` with `din` and set `ts` to 1. Next state is ARMED.
- ARMED: each cycle `ts` increments and saturates at all-ones with no wrap. If `din != last`, push `{din, ts}` and update `last`. A steady `din` pushes nothing.
- `stop`=1 in FIRST or ARMED moves to IDLE on that edge. A change sampled on the same edge is still pushed.
- `arm` while ARMED is ignored. `stop` and `arm` together in IDLE: `stop` wins and the block stays IDLE.
- Contents survive `stop` and survive re-arming. Re-arming restarts `ts` at 0.
- The host pops on the cycle where `out_valid && out_ready`.
- Full FIFO with a push and no pop: the event is dropped, `overflow` is set, and `drop_cnt` increments. Existing entries are never overwritten.
- Full FIFO with a push and a pop on the same edge: both are accepted and `level` is unchanged.
- Empty FIFO with a push: the entry is written and `out_valid` rises the next cycle. There is no fall-through in the same cycle.
- `overflow` and `drop_cnt` clear only on `rst`.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_data`=0, `out_ts`=0, `armed`=0, `overflow`=0, `drop_cnt`=0, `level`=0, `last`=0, `ts`=0. FIFO pointers are 0.
- `rst` takes effect mid-capture on the next edge. It flushes the FIFO, discards any same-cycle push or pop, and returns to IDLE.
- Latency: a change of `din` sampled at edge N is registered at edge N. `out_valid`, `out_data` and `out_ts` reflect it after edge N, which is 1 cycle.
- `armed` rises after the FIRST edge, i.e. 2 edges after `arm` is sampled.
- Timestamp meaning: the FIRST edge is 0, and each ARMED edge is 1 more than the previous edge.
- Head outputs are registered from FIFO storage. `out_data` and `out_ts` stay stable while `out_valid && !out_ready`.
- `level` is updated on the same edge as the push or pop.
- No combinational path from `out_ready` to `out_valid`.

## Test plan
- Stimulus-mirror: arm at cycle 0. Drive `din`=1010, then 1100 at ts 50, then 0000 at ts 150. Hold `out_ready`=1. Required: exactly three events, (1010,0), (1100,50), (0000,150), and `overflow`=0.
- Overflow: `DEPTH`=8, `out_ready`=0, toggle `din` every cycle for 12 ARMED cycles. Required: `level`=8, `overflow`=1, `drop_cnt`=5 (1 FIRST + 12 changes − 8). Draining then yields the first 8 events in order.
- Full simultaneous push/pop: fill to 8, then assert `out_ready`=1 and change `din` on the same cycle. Required: `level` stays 8, `drop_cnt` unchanged, and the new event appears last.
- Timestamp saturation: `TS_WIDTH`=4, arm, hold `din` steady for 20 cycles, then change it. Required: the event is logged with ts=15.
- Stop/re-arm: stop at ts 30 with 2 events queued, then re-arm with `din`=0111. Required: the queue holds the old 2 events, then (0111,0). `armed` is 0 for exactly the IDLE cycles.
- Reset mid-capture: 3 events queued, pulse `rst` with `out_ready`=1. Required: after the edge all outputs are at reset values and `level`=0. No pop is seen by the host on the reset cycle.

Source files
------------

// File: rtl/sample_capture_if.sv
// Host-side event port of sample_capture.
// The block drives head event fields; the host answers with ready.
interface sample_capture_if #(
  parameter int WIDTH    = 4,
  parameter int TS_WIDTH = 16
);
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_data;
  logic [TS_WIDTH-1:0] out_ts;

  modport master (
    output out_valid,
    output out_data,
    output out_ts,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ts,
    output out_ready
  );
endinterface

// File: rtl/sample_capture.sv
// Change-capture logger: timestamps every change of din into a FIFO
// drained by the host over a valid/ready port.
module sample_capture #(
  parameter int WIDTH    = 4,
  parameter int TS_WIDTH = 16,
  parameter int DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  input  logic                   arm,
  input  logic                   stop,
  sample_capture_if.master       out,
  output logic                   armed,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + TS_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    ARMED
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0]    last;
  logic [TS_WIDTH-1:0] ts;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nx;
  logic [AW:0]   count;
  logic [AW:0]   count_nx;

  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic          drop;
  logic [EW-1:0] ev;
  logic [EW-1:0] head_nx;

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    ev       = {din, ts};
    unique case (state)
      IDLE: begin
        if (!stop && arm)
          state_nx = FIRST;
      end
      FIRST: begin
        push     = 1'b1;
        ev       = {din, {TS_WIDTH{1'b0}}};
        state_nx = stop ? IDLE : ARMED;
      end
      ARMED: begin
        push = (din != last);
        if (stop)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // ts is 0 in FIRST, then counts ARMED edges and saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= '0;
      ts   <= '0;
    end else begin
      if (state == FIRST)
        last <= din;
      else if (state == ARMED && din != last)
        last <= din;

      if (state_nx != ARMED)
        ts <= '0;
      else if (state == FIRST)
        ts <= TS_WIDTH'(1);
      else if (ts != '1)
        ts <= ts + TS_WIDTH'(1);
    end
  end

  always_comb begin
    full  = (count == (AW+1)'(DEPTH));
    pop   = out.out_valid && out.out_ready;
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;
    rd_nx = pop ? rd_ptr + AW'(1) : rd_ptr;

    count_nx = count;
    if (wr_en && !pop)
      count_nx = count + (AW+1)'(1);
    else if (!wr_en && pop)
      count_nx = count - (AW+1)'(1);

    // A write landing on the next head slot bypasses storage.
    if (wr_en && wr_ptr == rd_nx)
      head_nx = ev;
    else
      head_nx = mem[rd_nx];
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en)
      mem[wr_ptr] <= ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      out.out_valid <= 1'b0;
      out.out_data  <= '0;
      out.out_ts    <= '0;
      overflow      <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr        <= rd_nx;
      count         <= count_nx;
      out.out_valid <= (count_nx != '0);
      if (count_nx != '0)
        {out.out_data, out.out_ts} <= head_nx;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign armed = (state == ARMED);
  assign level = count;

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture: capture, overflow,
// full push/pop, stop/re-arm, reset and timestamp saturation.
module tb_sample_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic       arm;
  logic       stop;
  logic       armed;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic [3:0] level;

  logic [3:0] din2;
  logic       arm2;
  logic       stop2;
  logic       armed2;
  logic       overflow2;
  logic [7:0] drop_cnt2;
  logic [3:0] level2;

  int checks = 0;
  int errors = 0;

  logic [19:0] popq [$];

  sample_capture_if #(.WIDTH(4), .TS_WIDTH(16)) ifc ();
  sample_capture_if #(.WIDTH(4), .TS_WIDTH(4))  ifc2 ();

  sample_capture #(
    .WIDTH(4), .TS_WIDTH(16), .DEPTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .arm      (arm),
    .stop     (stop),
    .out      (ifc),
    .armed    (armed),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .level    (level)
  );

  sample_capture #(
    .WIDTH(4), .TS_WIDTH(4), .DEPTH(8)
  ) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .din      (din2),
    .arm      (arm2),
    .stop     (stop2),
    .out      (ifc2),
    .armed    (armed2),
    .overflow (overflow2),
    .drop_cnt (drop_cnt2),
    .level    (level2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && ifc.out_valid && ifc.out_ready)
      popq.push_back({ifc.out_data, ifc.out_ts});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    din = 4'h0;
    arm = 1'b0;
    stop = 1'b0;
    ifc.out_ready = 1'b0;
    din2 = 4'h0;
    arm2 = 1'b0;
    stop2 = 1'b0;
    ifc2.out_ready = 1'b0;
    tick(2);

    chk("rst_valid", 32'(ifc.out_valid), 0);
    chk("rst_data", 32'(ifc.out_data), 0);
    chk("rst_ts", 32'(ifc.out_ts), 0);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_level", 32'(level), 0);
    rst = 1'b0;

    // stimulus mirror
    ifc.out_ready = 1'b1;
    din = 4'b1010;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    chk("first_armed", 32'(armed), 0);
    tick(1);
    chk("arm_armed", 32'(armed), 1);
    chk("first_valid", 32'(ifc.out_valid), 1);
    chk("first_data", 32'(ifc.out_data), 32'hA);
    chk("first_ts", 32'(ifc.out_ts), 0);
    arm = 1'b1;
    tick(49);
    arm = 1'b0;
    din = 4'b1100;
    tick(1);
    chk("ev2_valid", 32'(ifc.out_valid), 1);
    chk("ev2_ts", 32'(ifc.out_ts), 50);
    tick(99);
    din = 4'b0000;
    tick(1);
    tick(2);
    chk("mir_n", popq.size(), 3);
    chk("mir_e0", 32'(popq[0]), 32'h0A0000);
    chk("mir_e1", 32'(popq[1]), 32'h0C0032);
    chk("mir_e2", 32'(popq[2]), 32'h000096);
    chk("mir_ovf", 32'(overflow), 0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("mir_stop", 32'(armed), 0);
    chk("mir_level", 32'(level), 0);

    // overflow
    popq.delete();
    ifc.out_ready = 1'b0;
    din = 4'h0;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(1);
    for (int i = 0; i < 12; i++) begin
      din = (i % 2 == 0) ? 4'hF : 4'h0;
      tick(1);
    end
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("ovf_level", 32'(level), 8);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_drop", 32'(drop_cnt), 5);
    chk("ovf_hdata", 32'(ifc.out_data), 0);
    chk("ovf_hts", 32'(ifc.out_ts), 0);
    ifc.out_ready = 1'b1;
    tick(8);
    ifc.out_ready = 1'b0;
    chk("ovf_n", popq.size(), 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("ovf_e%0d", k), 32'(popq[k]),
          32'({((k % 2 == 1) ? 4'hF : 4'h0), 16'(k)}));
    chk("ovf_empty", 32'(level), 0);

    // full with simultaneous push and pop
    popq.delete();
    din = 4'h0;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(1);
    for (int i = 0; i < 7; i++) begin
      din = (i % 2 == 0) ? 4'hF : 4'h0;
      tick(1);
    end
    chk("pp_fill", 32'(level), 8);
    din = 4'h0;
    ifc.out_ready = 1'b1;
    tick(1);
    ifc.out_ready = 1'b0;
    chk("pp_level", 32'(level), 8);
    chk("pp_drop", 32'(drop_cnt), 5);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    ifc.out_ready = 1'b1;
    tick(8);
    ifc.out_ready = 1'b0;
    chk("pp_n", popq.size(), 9);
    chk("pp_e0", 32'(popq[0]), 32'h000000);
    chk("pp_e7", 32'(popq[7]), 32'h0F0007);
    chk("pp_last", 32'(popq[8]), 32'h000008);

    // stop then re-arm
    popq.delete();
    din = 4'h1;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(1);
    tick(9);
    din = 4'h2;
    tick(1);
    tick(19);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("sr_armed0", 32'(armed), 0);
    chk("sr_level", 32'(level), 2);
    tick(3);
    chk("sr_idle", 32'(armed), 0);
    din = 4'b0111;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    chk("sr_first", 32'(armed), 0);
    tick(1);
    chk("sr_armed1", 32'(armed), 1);
    chk("sr_level3", 32'(level), 3);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    ifc.out_ready = 1'b1;
    tick(3);
    ifc.out_ready = 1'b0;
    chk("sr_n", popq.size(), 3);
    chk("sr_e0", 32'(popq[0]), 32'h010000);
    chk("sr_e1", 32'(popq[1]), 32'h02000A);
    chk("sr_e2", 32'(popq[2]), 32'h070000);

    // stop beats arm in IDLE
    arm = 1'b1;
    stop = 1'b1;
    tick(2);
    arm = 1'b0;
    stop = 1'b0;
    chk("sa_armed", 32'(armed), 0);
    chk("sa_level", 32'(level), 0);

    // reset mid-capture
    popq.delete();
    din = 4'h0;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(1);
    din = 4'h1;
    tick(1);
    din = 4'h2;
    tick(1);
    chk("rm_level3", 32'(level), 3);
    ifc.out_ready = 1'b1;
    rst = 1'b1;
    tick(1);
    chk("rm_valid", 32'(ifc.out_valid), 0);
    chk("rm_data", 32'(ifc.out_data), 0);
    chk("rm_ts", 32'(ifc.out_ts), 0);
    chk("rm_armed", 32'(armed), 0);
    chk("rm_ovf", 32'(overflow), 0);
    chk("rm_drop", 32'(drop_cnt), 0);
    chk("rm_level", 32'(level), 0);
    chk("rm_nopop", popq.size(), 0);
    rst = 1'b0;
    ifc.out_ready = 1'b0;

    // timestamp saturation with 4-bit ts
    din2 = 4'h5;
    arm2 = 1'b1;
    tick(1);
    arm2 = 1'b0;
    tick(1);
    tick(20);
    din2 = 4'hA;
    tick(1);
    chk("sat_level", 32'(level2), 2);
    chk("sat_head", 32'(ifc2.out_ts), 0);
    ifc2.out_ready = 1'b1;
    tick(1);
    ifc2.out_ready = 1'b0;
    chk("sat_data", 32'(ifc2.out_data), 32'hA);
    chk("sat_ts", 32'(ifc2.out_ts), 15);
    chk("sat_lvl1", 32'(level2), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
